hpc2_unshare: RTL



---
 rtl/hpc2_unshare_pkg.sv | 31 +++
 rtl/hpc2_unshare_ring_refresh.sv | 33 +++
 rtl/hpc2_unshare.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hpc2_unshare_pkg.sv
// hpc2_unshare_pkg
// Shared masking definitions used by the unshare unit and by other gadgets
// that slice or refresh Boolean-shared words.
//   N_SHARES    : default share count
//   MAX_W       : widest single share share_slice can return
//   MAX_VEC     : widest shared vector share_slice accepts
//   state_t     : unshare FSM states
//   share_slice : extract share i (w bits wide) from a packed shared vector
package hpc2_unshare_pkg;

  localparam int N_SHARES = 3;
  localparam int MAX_W    = 64;
  localparam int MAX_VEC  = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Callers zero-extend their vector to MAX_VEC bits and cast the result
  // down to their own share width.
  function automatic logic [MAX_W-1:0] share_slice(input logic [MAX_VEC-1:0] vec,
                                                   input int i,
                                                   input int w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return MAX_W'(vec >> (i * w)) & mask;
  endfunction

endpackage

// File: rtl/hpc2_unshare_ring_refresh.sv
// hpc2_unshare_ring_refresh
// Combinational ring refresh of an N-share Boolean-masked word:
//   share_out_i = share_in_i ^ r_i ^ r_((i+1) mod N)
// Each r_i appears in exactly two output shares, so the XOR of all output
// shares equals the XOR of all input shares.
// Ports:
//   share_in  [N*W] : input shares, share i at bits [i*W +: W]
//   rand_in   [N*W] : fresh randomness, slice r_i at bits [i*W +: W]
//   share_out [N*W] : refreshed shares, same layout
module hpc2_unshare_ring_refresh
  import hpc2_unshare_pkg::*;
#(
  parameter int W = 8,
  parameter int N = N_SHARES
) (
  input  logic [N*W-1:0] share_in,
  input  logic [N*W-1:0] rand_in,
  output logic [N*W-1:0] share_out
);

  logic [MAX_VEC-1:0] share_pad;
  logic [MAX_VEC-1:0] rand_pad;

  assign share_pad = MAX_VEC'(share_in);
  assign rand_pad  = MAX_VEC'(rand_in);

  for (genvar gi = 0; gi < N; gi++) begin : g_share
    assign share_out[gi*W +: W] = W'(share_slice(share_pad, gi, W))
                                ^ W'(share_slice(rand_pad, gi, W))
                                ^ W'(share_slice(rand_pad, (gi + 1) % N, W));
  end

endmodule

// File: rtl/hpc2_unshare.sv
// hpc2_unshare
// Takes one N-share masked word plus N*W bits of fresh randomness, ring
// refreshes it into share_reg, then folds one share per cycle into acc so no
// combinational cone ever combines all shares. The unmasked value is then
// presented until accepted.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   sdi_data/valid/ready: shared input word (share i at [i*W +: W])
//   rdi_data/valid/ready: refresh randomness (slice i at [i*W +: W])
//   do_data/valid/ready : unmasked result; do_data is 0 while do_valid is 0
module hpc2_unshare
  import hpc2_unshare_pkg::*;
#(
  parameter int W = 8,
  parameter int N = N_SHARES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] sdi_data,
  input  logic           sdi_valid,
  output logic           sdi_ready,
  input  logic [N*W-1:0] rdi_data,
  input  logic           rdi_valid,
  output logic           rdi_ready,
  output logic [W-1:0]   do_data,
  output logic           do_valid,
  input  logic           do_ready
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t              state_reg, state_next;
  logic [KW-1:0]       k_reg, k_next;
  logic [W-1:0]        acc_reg, acc_next;
  logic [N-1:0][W-1:0] share_reg;
  logic [N*W-1:0]      refreshed;
  logic [W-1:0]        fold_share;
  logic                capture;

  hpc2_unshare_ring_refresh #(.W(W), .N(N)) u_refresh (
    .share_in  (sdi_data),
    .rand_in   (rdi_data),
    .share_out (refreshed)
  );

  // Data and randomness are only ever taken together.
  assign capture    = (state_reg == IDLE) && sdi_valid && rdi_valid;
  assign fold_share = share_reg[k_reg];

  // Readies are gated by rst so they drop the instant reset asserts.
  assign sdi_ready = !rst && (state_reg == IDLE) && rdi_valid;
  assign rdi_ready = !rst && (state_reg == IDLE) && sdi_valid;
  assign do_valid  = (state_reg == OUT);
  assign do_data   = do_valid ? acc_reg : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      acc_reg   <= acc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    acc_next   = acc_reg;
    case (state_reg)
      IDLE: begin
        if (capture) begin
          state_next = FOLD;
          k_next     = '0;
          acc_next   = '0;
        end
      end
      FOLD: begin
        acc_next = acc_reg ^ fold_share;
        if (k_reg == K_LAST) begin
          // Park the counter instead of stepping past the last share.
          state_next = OUT;
          k_next     = '0;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      OUT: begin
        if (do_ready) begin
          state_next = IDLE;
          acc_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        k_next     = '0;
        acc_next   = '0;
      end
    endcase
  end

  // Refreshed shares are loaded on capture; each share is wiped in the cycle
  // it is folded so consumed shares do not linger in the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      share_reg <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (capture) begin
          share_reg[i] <= refreshed[i*W +: W];
        end else if ((state_reg == FOLD) && (k_reg == KW'(i))) begin
          share_reg[i] <= '0;
        end
      end
    end
  end

endmodule
